// File: rtl/decoder_pkg.sv
// Shared encodings for the sequenced decoder: command modes and FSM states.
package decoder_pkg;

   // Command mode carried on the mode port
   typedef enum logic [1:0] {
      MODE_ONEHOT = 2'b00,
      MODE_THERMO = 2'b01,
      MODE_SCAN   = 2'b10,
      MODE_CLEAR  = 2'b11
   } mode_e;

   // Controller states: idle, holding a static result, or scanning
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_STATIC = 2'b01,
      ST_SCAN   = 2'b10
   } state_e;

endpackage

// File: rtl/dec_core.sv
// Combinational select decoder: produces both the one-hot and the
// thermometer code of a SEL_W-bit select over OUT_W = 2**SEL_W outputs.
// Every select value maps to a valid code, so there is no range check.
module dec_core #(
   parameter  int SEL_W = 3,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic [SEL_W-1:0] sel_i,
   output logic [OUT_W-1:0] onehot_o,
   output logic [OUT_W-1:0] thermo_o
);

   // Each bit compares its own index to the select: equal gives one-hot, not-above gives thermometer
   always_comb begin
      onehot_o = '0;
      thermo_o = '0;
      for (int i = 0; i < OUT_W; i++) begin
         onehot_o[i] = (SEL_W'(i) == sel_i);
         thermo_o[i] = (SEL_W'(i) <= sel_i);
      end
   end

endmodule

// File: rtl/decoder_seq.sv
// Sequenced decoder. Accepts ONEHOT/THERMO/SCAN/CLEAR commands through a
// valid/ready handshake and presents the decoded result one cycle later on
// a registered output. Static results wait for out_ready; SCAN walks a
// one-hot position round the output, holding each position dwell+1 cycles.
module decoder_seq
   import decoder_pkg::*;
#(
   parameter  int SEL_W   = 3,
   parameter  int DWELL_W = 4,
   localparam int OUT_W   = 2**SEL_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic [1:0]         mode,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   out,
   output logic               out_valid,
   input  logic               out_ready
);

   state_e               state_q,     state_d;
   logic [OUT_W-1:0]     out_q,       out_d;
   logic                 out_valid_q, out_valid_d;
   logic [SEL_W-1:0]     pos_q,       pos_d;
   logic [DWELL_W-1:0]   cnt_q,       cnt_d;
   logic [DWELL_W-1:0]   reload_q,    reload_d;

   logic                 in_ready_s;
   logic                 accept_s;
   logic                 adv_s;
   logic [SEL_W-1:0]     pos_next_s;
   logic [SEL_W-1:0]     dec_sel_s;
   logic [OUT_W-1:0]     onehot_s;
   logic [OUT_W-1:0]     thermo_s;
   mode_e                mode_s;

   assign mode_s = mode_e'(mode);

   // Ready is withheld during reset and while a static result awaits out_ready
   always_comb begin
      in_ready_s = 1'b0;
      if (!reset) begin
         in_ready_s = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:   in_ready_s = 1'b1;
            ST_STATIC: in_ready_s = out_ready;
            ST_SCAN:   in_ready_s = 1'b1;
            default:   in_ready_s = 1'b0;
         endcase
      end
   end

   assign accept_s = in_valid && in_ready_s;

   // Scan position steps when the hold counter has run out; the select width makes it wrap
   always_comb begin
      adv_s      = 1'b0;
      pos_next_s = pos_q;
      if ((state_q == ST_SCAN) && (cnt_q == '0)) begin
         adv_s      = 1'b1;
         pos_next_s = pos_q + SEL_W'(1);
      end else begin
         adv_s      = 1'b0;
         pos_next_s = pos_q;
      end
   end

   // A new command always takes the decoder; otherwise decode the upcoming scan position
   always_comb begin
      dec_sel_s = pos_next_s;
      if (accept_s) begin
         dec_sel_s = sel;
      end else begin
         dec_sel_s = pos_next_s;
      end
   end

   dec_core #(
      .SEL_W (SEL_W)
   ) u_dec_core (
      .sel_i    (dec_sel_s),
      .onehot_o (onehot_s),
      .thermo_o (thermo_s)
   );

   // Next-state and next-output logic; an accepted command overrides any scan step
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      pos_d       = pos_q;
      cnt_d       = cnt_q;
      reload_d    = reload_q;
      if (accept_s) begin
         case (mode_s)
            MODE_ONEHOT: begin
               out_d       = onehot_s;
               out_valid_d = 1'b1;
               state_d     = ST_STATIC;
            end
            MODE_THERMO: begin
               out_d       = thermo_s;
               out_valid_d = 1'b1;
               state_d     = ST_STATIC;
            end
            MODE_SCAN: begin
               pos_d       = sel;
               reload_d    = dwell;
               cnt_d       = dwell;
               out_d       = onehot_s;
               out_valid_d = 1'b1;
               state_d     = ST_SCAN;
            end
            MODE_CLEAR: begin
               out_d       = '0;
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
            default: begin
               out_d       = '0;
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         endcase
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_STATIC: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  out_valid_d = out_valid_q;
                  state_d     = ST_STATIC;
               end
            end
            ST_SCAN: begin
               if (adv_s) begin
                  pos_d = pos_next_s;
                  cnt_d = reload_q;
                  out_d = onehot_s;
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
            default: begin
               out_d       = '0;
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         endcase
      end
   end

   // State, position, hold counter and output registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         pos_q       <= '0;
         cnt_q       <= '0;
         reload_q    <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         pos_q       <= pos_d;
         cnt_q       <= cnt_d;
         reload_q    <= reload_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL take parameter SEL_W, default 3, as the select width.
REQ-002 The block SHALL take parameter DWELL_W, default 4, as the scan dwell-count width.
REQ-003 The block SHALL derive localparam OUT_W = 2**SEL_W, default 8, as the output width.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that a command is presented.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the block accepts a command this cycle.
REQ-008 Port sel, input, SEL_W bits, SHALL carry the command select or start index.
REQ-009 Port mode, input, 2 bits, SHALL carry the command mode: 00 ONEHOT, 01 THERMO, 10 SCAN, 11 CLEAR.
REQ-010 Port dwell, input, DWELL_W bits, SHALL carry the SCAN hold count; each position holds for dwell+1 cycles.
REQ-011 Port out, output, OUT_W bits, SHALL be the registered decoded output.
REQ-012 Port out_valid, output, 1 bit, SHALL flag that out is meaningful.
REQ-013 Port out_ready, input, 1 bit, SHALL be the downstream acceptance signal for static results.

Function
REQ-014 A command SHALL be accepted on a cycle where in_valid && in_ready; out and out_valid SHALL reflect it exactly 1 cycle later.
REQ-015 The FSM SHALL have exactly three states: IDLE, STATIC and SCAN.
REQ-016 An accepted ONEHOT command SHALL produce out = 1 << sel and out_valid = 1, and move to STATIC.
REQ-017 An accepted THERMO command SHALL produce out bits [sel:0] = 1 and all other bits 0 (sel=0 gives 0x01; sel=OUT_W-1 gives all ones), and move to STATIC.
REQ-018 An accepted CLEAR command SHALL produce out = 0 and out_valid = 0, and move to IDLE.
REQ-019 In IDLE, in_ready SHALL be 1.
REQ-020 In STATIC, in_ready SHALL equal out_ready, and out/out_valid SHALL hold while out_ready = 0.
REQ-021 In STATIC, out_ready = 1 without a new accept SHALL return the FSM to IDLE with out_valid = 0 and out unchanged.
REQ-022 An accepted SCAN command SHALL latch sel as the position and dwell as the reload value, output out = 1 << position with out_valid = 1, and move to SCAN.
REQ-023 In SCAN, the position SHALL advance by 1 after dwell+1 cycles and wrap from OUT_W-1 to 0.
REQ-024 In SCAN, out_ready SHALL be ignored and in_ready SHALL be 1.
REQ-025 With dwell = 0, the SCAN position SHALL advance every cycle.
REQ-026 If an accept and a SCAN position advance fall in the same cycle, the new command SHALL win.
REQ-027 Changes to the dwell port after a SCAN command is accepted SHALL have no effect until the next SCAN command.
REQ-028 Every sel value SHALL be legal, with no out-of-range case.
REQ-029 out SHALL be exactly one-hot in ONEHOT and SCAN results.

Reset
REQ-030 While reset = 0, the block SHALL asynchronously force state = IDLE, out = 0, out_valid = 0, position = 0 and dwell counter = 0.
REQ-031 While reset = 0, in_ready SHALL be 0.
REQ-032 Assertion of reset mid-SCAN or mid-STATIC SHALL abort the operation with no pending command retained.
REQ-033 After reset deasserts, the first accept SHALL be possible on the next rising edge.

Structure
REQ-034 Package decoder_pkg SHALL hold the mode encoding enum and the FSM state enum.
REQ-035 Combinational decode (one-hot/thermometer of SEL_W to OUT_W) SHALL live in sub-module dec_core, parameterised by SEL_W.
REQ-036 The FSM, dwell counter, position register and output register SHALL reside in decoder_seq.

Verification
REQ-037 The bench SHALL apply reset low then high, check out=0x00, out_valid=0, then ONEHOT sel=5 with out_ready=1 -> next cycle out=0x20, out_valid=1.
REQ-038 The bench SHALL apply THERMO sel=3 with out_ready=0 for 4 cycles -> out=0x0F held, in_ready=0, then out_ready=1 -> out_valid drops the following cycle.
REQ-039 The bench SHALL apply SCAN sel=6, dwell=1 -> out 0x40, 0x40, 0x80, 0x80, 0x01, 0x01, 0x02 (wrap).
REQ-040 The bench SHALL apply SCAN dwell=0, then ONEHOT sel=2 on an advance cycle -> next out=0x04 with FSM in STATIC.
REQ-041 The bench SHALL pulse reset low mid-SCAN asynchronously -> out=0x00, out_valid=0 immediately, and no advance after release.
REQ-042 The bench SHALL re-run the scenarios of REQ-037 to REQ-041 with SEL_W=4 -> ONEHOT sel=15 gives 0x8000 and SCAN wraps 15 to 0.
